spiking_neural_network: RTL and testbench

Fixed-topology, three-layer leaky integrate-and-fire spiking network. Three 1-bit input spike lines feed three hidden neurons, which feed two output neurons. All state is clocked, with one update per cycle. The block is the top of the SNN datapath: spike trains are driven in from a stimulus source, and output spikes go to downstream counters and monitors.

---
 rtl/spiking_neural_network.sv | 121 ++++++++++++
 tb/tb_spiking_neural_network.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spiking_neural_network.sv
// Three-layer leaky integrate-and-fire spiking network: 3 inputs -> 3 hidden -> 2 outputs.
// Neuron slots 0..4 hold n4, n5, n6 (hidden) and n7, n8 (output).
module spiking_neural_network #(
  parameter int POT_W  = 8,
  parameter int THRESH = 16,
  parameter int LEAK   = 1,
  parameter int REFRAC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic neuron_1,
  input  logic neuron_2,
  input  logic neuron_3,
  output logic neuron_7,
  output logic neuron_8
);

  // Accumulator is wide enough that potential plus every weight cannot overflow.
  localparam int ACC_W = POT_W + 4;
  // Width of the refractory counter; it must hold the value REFRAC.
  localparam int R_W   = $clog2(REFRAC + 2);
  localparam int N_NEU = 5;

  localparam logic signed [ACC_W-1:0] ZERO     = '0;
  localparam logic signed [ACC_W-1:0] THRESH_S = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] LEAK_S   = ACC_W'(LEAK);
  localparam logic signed [ACC_W-1:0] NLEAK_S  = ACC_W'(-LEAK);
  localparam logic signed [ACC_W-1:0] POT_MAX  = ACC_W'((1 <<< (POT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] POT_MIN  = ACC_W'(-(1 <<< (POT_W - 1)));

  // Synaptic weights, named W_<from>_<to>.
  localparam logic signed [ACC_W-1:0] W_1_4 = ACC_W'(10);
  localparam logic signed [ACC_W-1:0] W_2_4 = ACC_W'(10);
  localparam logic signed [ACC_W-1:0] W_3_4 = ACC_W'(-5);
  localparam logic signed [ACC_W-1:0] W_1_5 = ACC_W'(6);
  localparam logic signed [ACC_W-1:0] W_2_5 = ACC_W'(6);
  localparam logic signed [ACC_W-1:0] W_3_5 = ACC_W'(12);
  localparam logic signed [ACC_W-1:0] W_1_6 = ACC_W'(-4);
  localparam logic signed [ACC_W-1:0] W_2_6 = ACC_W'(8);
  localparam logic signed [ACC_W-1:0] W_3_6 = ACC_W'(10);
  localparam logic signed [ACC_W-1:0] W_4_7 = ACC_W'(12);
  localparam logic signed [ACC_W-1:0] W_5_7 = ACC_W'(8);
  localparam logic signed [ACC_W-1:0] W_6_7 = ACC_W'(-6);
  localparam logic signed [ACC_W-1:0] W_4_8 = ACC_W'(-6);
  localparam logic signed [ACC_W-1:0] W_5_8 = ACC_W'(8);
  localparam logic signed [ACC_W-1:0] W_6_8 = ACC_W'(12);

  logic signed [POT_W-1:0] pot_q [N_NEU];
  logic signed [POT_W-1:0] pot_d [N_NEU];
  logic        [R_W-1:0]   ref_q [N_NEU];
  logic        [R_W-1:0]   ref_d [N_NEU];
  logic        [N_NEU-1:0] spk_q;
  logic        [N_NEU-1:0] spk_d;
  logic signed [ACC_W-1:0] syn   [N_NEU];
  logic signed [ACC_W-1:0] acc   [N_NEU];
  logic signed [ACC_W-1:0] lk    [N_NEU];

  // Weighted sum of presynaptic spikes; output layer sees last edge's hidden spikes.
  always_comb begin
    syn[0] = (neuron_1 ? W_1_4 : ZERO) + (neuron_2 ? W_2_4 : ZERO) + (neuron_3 ? W_3_4 : ZERO);
    syn[1] = (neuron_1 ? W_1_5 : ZERO) + (neuron_2 ? W_2_5 : ZERO) + (neuron_3 ? W_3_5 : ZERO);
    syn[2] = (neuron_1 ? W_1_6 : ZERO) + (neuron_2 ? W_2_6 : ZERO) + (neuron_3 ? W_3_6 : ZERO);
    syn[3] = (spk_q[0] ? W_4_7 : ZERO) + (spk_q[1] ? W_5_7 : ZERO) + (spk_q[2] ? W_6_7 : ZERO);
    syn[4] = (spk_q[0] ? W_4_8 : ZERO) + (spk_q[1] ? W_5_8 : ZERO) + (spk_q[2] ? W_6_8 : ZERO);
  end

  // Per-neuron LIF step: refractory hold, fire on threshold, else leak toward 0 and saturate.
  always_comb begin
    for (int i = 0; i < N_NEU; i++) begin
      pot_d[i] = pot_q[i];
      ref_d[i] = ref_q[i];
      spk_d[i] = 1'b0;
      acc[i]   = ACC_W'(pot_q[i]) + syn[i];
      lk[i]    = ZERO;
      if (ref_q[i] != '0) begin
        ref_d[i] = ref_q[i] - R_W'(1);
        pot_d[i] = '0;
      end else if (acc[i] >= THRESH_S) begin
        spk_d[i] = 1'b1;
        pot_d[i] = '0;
        ref_d[i] = R_W'(REFRAC);
      end else begin
        if (acc[i] > LEAK_S) begin
          lk[i] = acc[i] - LEAK_S;
        end else if (acc[i] < NLEAK_S) begin
          lk[i] = acc[i] + LEAK_S;
        end else begin
          lk[i] = ZERO;
        end
        if (lk[i] > POT_MAX) begin
          pot_d[i] = POT_W'(POT_MAX);
        end else if (lk[i] < POT_MIN) begin
          pot_d[i] = POT_W'(POT_MIN);
        end else begin
          pot_d[i] = POT_W'(lk[i]);
        end
      end
    end
  end

  // State registers; reset clears every potential, refractory count and spike.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEU; i++) begin
        pot_q[i] <= '0;
        ref_q[i] <= '0;
      end
      spk_q <= '0;
    end else begin
      for (int i = 0; i < N_NEU; i++) begin
        pot_q[i] <= pot_d[i];
        ref_q[i] <= ref_d[i];
      end
      spk_q <= spk_d;
    end
  end

  assign neuron_7 = spk_q[3];
  assign neuron_8 = spk_q[4];

endmodule

// File: tb/tb_spiking_neural_network.sv
// Self-checking bench for spiking_neural_network against an integer-level network model.
module tb_spiking_neural_network;

  logic clk;
  logic rst_n;
  logic neuron_1;
  logic neuron_2;
  logic neuron_3;
  logic neuron_7;
  logic neuron_8;

  int nVectors = 0;
  int nMiscompares = 0;

  // Model state, slots 0..4 are n4..n8; presynaptic sources 0..5 are n1..n6.
  int mV[5];
  int mR[5];
  int mS[5];
  int wt[5][6] = '{'{10, 10, -5, 0, 0, 0},
                   '{ 6,  6, 12, 0, 0, 0},
                   '{-4,  8, 10, 0, 0, 0},
                   '{ 0,  0,  0, 12, 8, -6},
                   '{ 0,  0,  0, -6, 8, 12}};

  spiking_neural_network dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .neuron_1 (neuron_1),
    .neuron_2 (neuron_2),
    .neuron_3 (neuron_3),
    .neuron_7 (neuron_7),
    .neuron_8 (neuron_8)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it and report when observed differs from expected.
  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Model reset: every neuron back to rest.
  task automatic modelReset();
    for (int i = 0; i < 5; i++) begin
      mV[i] = 0;
      mR[i] = 0;
      mS[i] = 0;
    end
  endtask

  // Model edge: all neurons update at once from the old spike vector and the inputs.
  task automatic modelStep(input int a, input int b, input int c);
    int pre[6];
    int nV[5];
    int nR[5];
    int nS[5];
    int sum;
    pre[0] = a; pre[1] = b; pre[2] = c;
    pre[3] = mS[0]; pre[4] = mS[1]; pre[5] = mS[2];
    for (int n = 0; n < 5; n++) begin
      sum = mV[n];
      for (int p = 0; p < 6; p++) sum += pre[p] * wt[n][p];
      nS[n] = 0;
      if (mR[n] > 0) begin
        nR[n] = mR[n] - 1;
        nV[n] = 0;
      end else if (sum >= 16) begin
        nS[n] = 1;
        nV[n] = 0;
        nR[n] = 2;
      end else begin
        nR[n] = 0;
        if (sum > 1) nV[n] = sum - 1;
        else if (sum < -1) nV[n] = sum + 1;
        else nV[n] = 0;
        if (nV[n] > 127) nV[n] = 127;
        if (nV[n] < -128) nV[n] = -128;
      end
    end
    for (int n = 0; n < 5; n++) begin
      mV[n] = nV[n];
      mR[n] = nR[n];
      mS[n] = nS[n];
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the model past the edge.
  task automatic applyStimulus(input logic rst, input logic a, input logic b, input logic c);
    rst_n = rst;
    neuron_1 = a;
    neuron_2 = b;
    neuron_3 = c;
    @(posedge clk);
    #1;
    if (!rst) modelReset();
    else modelStep(int'(a), int'(b), int'(c));
  endtask

  // Compare both outputs against the model after the latest edge.
  task automatic checkModel(input string tag);
    checkOutput({tag, "_n7"}, neuron_7, mS[3]);
    checkOutput({tag, "_n8"}, neuron_8, mS[4]);
  endtask

  // Hold reset for three cycles so each scenario starts from rest.
  task automatic resetPhase(input logic a, input logic b, input logic c);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, a, b, c);
      checkOutput("rst_n7", neuron_7, 0);
      checkOutput("rst_n8", neuron_8, 0);
    end
  endtask

  // Scenario sequence: reset, single-input runs, alternating, mid-run reset, random.
  initial begin
    logic p7;
    logic p8;
    logic a;
    logic b;
    logic c;
    logic r;
    rst_n = 1'b0;
    neuron_1 = 1'b0;
    neuron_2 = 1'b0;
    neuron_3 = 1'b0;
    modelReset();

    // Reset with every input high, then the first edge after release.
    resetPhase(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rel_n7", neuron_7, 0);
    checkOutput("rel_n8", neuron_8, 0);

    // neuron_1 alone: n7 at edges 4 and 9, n8 silent, n6 driven into negative saturation.
    resetPhase(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkModel("n1only");
      checkOutput("n6_pot", dut.pot_q[2], mV[2]);
      checkOutput("n6_nowrap", (dut.pot_q[2] > 0) ? 1 : 0, 0);
      if (k == 4 || k == 9) checkOutput("n1_n7_fire", neuron_7, 1);
      if (k <= 20) checkOutput("n1_n8_quiet", neuron_8, 0);
    end
    checkOutput("n6_clamp", dut.pot_q[2], -128);

    // neuron_3 alone: n8 at edges 3, 7, 11 and n7 never.
    resetPhase(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkModel("n3only");
      checkOutput("n3_n7_quiet", neuron_7, 0);
      checkOutput("n3_n8_sched", neuron_8, (k == 3 || k == 7 || k == 11) ? 1 : 0);
    end

    // Alternating neuron_1/neuron_2; no output may stay high two cycles running.
    resetPhase(1'b0, 1'b0, 1'b0);
    p7 = 1'b0;
    p8 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      applyStimulus(1'b1, logic'(k % 2), logic'((k + 1) % 2), 1'b0);
      checkModel("alt");
      checkOutput("alt_n7_consec", neuron_7 & p7, 0);
      checkOutput("alt_n8_consec", neuron_8 & p8, 0);
      p7 = neuron_7;
      p8 = neuron_8;
    end

    // Reset for one edge after edge 5 of the neuron_3 run; schedule restarts.
    resetPhase(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkModel("mid_pre");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid_rst_n7", neuron_7, 0);
    checkOutput("mid_rst_n8", neuron_8, 0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkModel("mid_post");
      checkOutput("mid_n8_sched", neuron_8, (k == 3 || k == 7 || k == 11) ? 1 : 0);
    end

    // Random spike trains with occasional resets against the model.
    resetPhase(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      a = logic'($urandom_range(0, 1));
      b = logic'($urandom_range(0, 1));
      c = logic'($urandom_range(0, 1));
      r = ($urandom_range(0, 29) != 0);
      applyStimulus(r, a, b, c);
      checkModel("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
